// File: rtl/player_action_ctrl_pkg.sv
// Shared types and defaults for the per-player action sequencer.
// Both player instances import this package so that frame counts and
// damage values stay identical unless a top-level override says otherwise.
package player_action_ctrl_pkg;

  // Encoding is visible on the 'state' output port, so values are fixed.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WINDUP  = 3'd1,
    ACTIVE  = 3'd2,
    RECOVER = 3'd3,
    DEFEND  = 3'd4,
    STUN    = 3'd5,
    KO      = 3'd6
  } action_state_t;

  // Default frame counts (all phase lengths must fit the 6-bit frame counter).
  localparam int DFLT_WINDUP_F  = 3;
  localparam int DFLT_ACTIVE_F  = 2;
  localparam int DFLT_RECOVER_F = 4;
  localparam int DFLT_STUN_F    = 8;
  localparam int DFLT_DEF_MAX_F = 30;
  localparam int DFLT_DEF_CD_F  = 20;

  // Default HP bookkeeping.
  localparam int DFLT_HP_INIT   = 100;
  localparam int DFLT_DMG       = 10;
  localparam int DFLT_DMG_DEF   = 2;

  // HP subtraction that floors at zero instead of wrapping.
  function automatic logic [7:0] hp_sub(input logic [7:0] cur, input logic [7:0] dmg);
    return (cur > dmg) ? (cur - dmg) : 8'd0;
  endfunction

endpackage

// File: rtl/player_action_ctrl_btn_edge.sv
// Rising-edge detector for a debounced button level.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in         : button level
//   rise       : high in the cycle the level is 1 and was 0 the cycle before
// The previous level is registered; rise is combinational from it so the
// consuming FSM reacts in the same cycle the press is first seen.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= in;
  end

  assign rise = in & ~prev;

endmodule

// File: rtl/player_action_ctrl.sv
// Per-player action sequencer.
// Sits between the debounced buttons and the player position datapath:
// frame-gates movement/jump, sequences attacks (windup/active/recover with a
// one-deep re-attack buffer), runs a time-limited defend with cooldown, and
// handles hit-stun and HP down to a terminal KO.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   frame_tick          : one-cycle pulse per game frame
//   btn_*               : debounced button levels
//   is_jump             : jump in progress (from position datapath)
//   hit                 : one-cycle pulse, this player was struck
//   right, left, jump   : one-cycle movement strobes (cycle after the tick)
//   squat, defend       : levels to the position datapath
//   atk_active          : attack hitbox live
//   state               : current action_state_t
//   hp, ko              : remaining HP, HP exhausted
// All outputs are registered.
module player_action_ctrl
  import player_action_ctrl_pkg::*;
#(
  parameter int WINDUP_F  = DFLT_WINDUP_F,
  parameter int ACTIVE_F  = DFLT_ACTIVE_F,
  parameter int RECOVER_F = DFLT_RECOVER_F,
  parameter int STUN_F    = DFLT_STUN_F,
  parameter int DEF_MAX_F = DFLT_DEF_MAX_F,
  parameter int DEF_CD_F  = DFLT_DEF_CD_F,
  parameter int HP_INIT   = DFLT_HP_INIT,
  parameter int DMG       = DFLT_DMG,
  parameter int DMG_DEF   = DFLT_DMG_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_right,
  input  logic       btn_left,
  input  logic       btn_jump,
  input  logic       btn_squat,
  input  logic       btn_defend,
  input  logic       btn_attack,
  input  logic       is_jump,
  input  logic       hit,
  output logic       right,
  output logic       left,
  output logic       jump,
  output logic       squat,
  output logic       defend,
  output logic       atk_active,
  output logic [2:0] state,
  output logic [7:0] hp,
  output logic       ko
);

  // Last frame index of each phase: a phase ends on the tick that sees this.
  localparam logic [5:0] WINDUP_LAST  = 6'(WINDUP_F  - 1);
  localparam logic [5:0] ACTIVE_LAST  = 6'(ACTIVE_F  - 1);
  localparam logic [5:0] RECOVER_LAST = 6'(RECOVER_F - 1);
  localparam logic [5:0] STUN_LAST    = 6'(STUN_F    - 1);
  localparam logic [5:0] DEF_LAST     = 6'(DEF_MAX_F - 1);
  localparam logic [5:0] CD_LOAD      = 6'(DEF_CD_F);
  localparam logic [7:0] HP_RST       = 8'(HP_INIT);
  localparam logic [7:0] DMG_HIT      = 8'(DMG);
  localparam logic [7:0] DMG_BLK      = 8'(DMG_DEF);

  action_state_t st, st_n;
  logic [5:0]    fcnt, fcnt_n;
  logic [5:0]    cd, cd_n;
  logic          atk_buf, atk_buf_n;
  logic [7:0]    hp_n;
  logic          atk_rise;
  logic [5:0]    phase_last;
  logic          phase_done;
  logic          move_ok;
  logic          right_n, left_n, jump_n, squat_n;

  btn_edge u_atk_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (btn_attack),
    .rise (atk_rise)
  );

  // Length of the phase the FSM is currently in.
  always_comb begin
    phase_last = 6'd0;
    case (st)
      WINDUP:  phase_last = WINDUP_LAST;
      ACTIVE:  phase_last = ACTIVE_LAST;
      RECOVER: phase_last = RECOVER_LAST;
      DEFEND:  phase_last = DEF_LAST;
      STUN:    phase_last = STUN_LAST;
      default: phase_last = 6'd0;
    endcase
  end

  assign phase_done = frame_tick && (fcnt == phase_last);

  // Next state, HP and attack buffer.
  always_comb begin
    st_n      = st;
    hp_n      = hp;
    atk_buf_n = atk_buf;

    case (st)
      IDLE: begin
        // Defend wins over a simultaneous attack press.
        if (btn_defend && !is_jump && (cd == 6'd0)) st_n = DEFEND;
        else if (atk_rise)                          st_n = WINDUP;
      end
      WINDUP: begin
        if (phase_done) st_n = ACTIVE;
      end
      ACTIVE: begin
        if (atk_rise)   atk_buf_n = 1'b1;
        if (phase_done) st_n = RECOVER;
      end
      RECOVER: begin
        if (phase_done) begin
          // A press landing on the exit cycle still counts as buffered.
          if (atk_buf || atk_rise) begin
            st_n      = WINDUP;
            atk_buf_n = 1'b0;
          end else begin
            st_n = IDLE;
          end
        end else if (atk_rise) begin
          atk_buf_n = 1'b1;
        end
      end
      DEFEND: begin
        if (!btn_defend || phase_done) st_n = IDLE;
      end
      STUN: begin
        if (phase_done) st_n = IDLE;
      end
      KO: begin
        st_n = KO;
      end
      default: st_n = IDLE;
    endcase

    // Hits override whatever the tick logic decided this cycle.
    // STUN and KO are invulnerable.
    if (hit && (st != KO) && (st != STUN)) begin
      if (st == DEFEND) begin
        hp_n = hp_sub(hp, DMG_BLK);
      end else begin
        hp_n      = hp_sub(hp, DMG_HIT);
        st_n      = STUN;
        atk_buf_n = 1'b0;
      end
      if (hp_n == 8'd0) st_n = KO;
    end
  end

  // Frame counter restarts on every state change so each phase counts from 0.
  always_comb begin
    fcnt_n = fcnt;
    if (st_n != st)      fcnt_n = 6'd0;
    else if (frame_tick) fcnt_n = fcnt + 6'd1;
  end

  // Defend cooldown: loaded on any DEFEND exit, then drains one per frame.
  always_comb begin
    cd_n = cd;
    if ((st == DEFEND) && (st_n != DEFEND)) cd_n = CD_LOAD;
    else if (frame_tick && (cd != 6'd0))    cd_n = cd - 6'd1;
  end

  // Output qualification uses the current state; KO on the next state masks
  // a strobe that would otherwise fire in the cycle the player is knocked out.
  always_comb begin
    move_ok = frame_tick && !squat && (st_n != KO) &&
              ((st == IDLE) || (st == WINDUP) || (st == RECOVER));
    right_n = move_ok && btn_right;
    left_n  = move_ok && btn_left && !btn_right;
    jump_n  = frame_tick && btn_jump && (st == IDLE) && !is_jump &&
              !btn_squat && (st_n != KO);
    squat_n = btn_squat && (st == IDLE) && !is_jump && (st_n != KO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      fcnt    <= 6'd0;
      cd      <= 6'd0;
      atk_buf <= 1'b0;
      hp      <= HP_RST;
    end else begin
      st      <= st_n;
      fcnt    <= fcnt_n;
      cd      <= cd_n;
      atk_buf <= atk_buf_n;
      hp      <= hp_n;
    end
  end

  // Levels derived from the next state so they line up with 'state'.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      right      <= 1'b0;
      left       <= 1'b0;
      jump       <= 1'b0;
      squat      <= 1'b0;
      defend     <= 1'b0;
      atk_active <= 1'b0;
      ko         <= 1'b0;
    end else begin
      right      <= right_n;
      left       <= left_n;
      jump       <= jump_n;
      squat      <= squat_n;
      defend     <= (st_n == DEFEND);
      atk_active <= (st_n == ACTIVE);
      ko         <= (hp_n == 8'd0);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_player_action_ctrl.sv
// Scoreboard bench for player_action_ctrl (HP_INIT overridden to 25 so KO
// is reachable with a saturating final hit). Stimulus pushes the expected
// output snapshot plus the frame index at which it must appear; the monitor
// pops on every strobe or level change and compares.
module tb_player_action_ctrl;
  import player_action_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic btn_right = 1'b0, btn_left = 1'b0, btn_jump = 1'b0;
  logic btn_squat = 1'b0, btn_defend = 1'b0, btn_attack = 1'b0;
  logic is_jump = 1'b0, hit = 1'b0;
  logic right, left, jump, squat, defend, atk_active, ko;
  logic [2:0] state;
  logic [7:0] hp;

  always #5 clk = ~clk;

  player_action_ctrl #(.HP_INIT(25)) u_dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .btn_right(btn_right), .btn_left(btn_left), .btn_jump(btn_jump),
    .btn_squat(btn_squat), .btn_defend(btn_defend), .btn_attack(btn_attack),
    .is_jump(is_jump), .hit(hit),
    .right(right), .left(left), .jump(jump), .squat(squat), .defend(defend),
    .atk_active(atk_active), .state(state), .hp(hp), .ko(ko)
  );

  // flags = {right,left,jump,squat,defend,atk_active,ko}
  localparam logic [6:0] F_0 = 7'b0000000;
  localparam logic [6:0] F_R = 7'b1000000;
  localparam logic [6:0] F_L = 7'b0100000;
  localparam logic [6:0] F_J = 7'b0010000;
  localparam logic [6:0] F_S = 7'b0001000;
  localparam logic [6:0] F_D = 7'b0000100;
  localparam logic [6:0] F_A = 7'b0000010;
  localparam logic [6:0] F_K = 7'b0000001;

  typedef struct {
    logic [2:0] st;
    logic [7:0] hp;
    logic [6:0] fl;
    int         tk;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  int tk = 0;       // ticks issued by stimulus
  int tk_seen = 0;  // ticks seen at clock edges

  // nt=1: the event is caused by (or follows) the next tick to be issued.
  task automatic ex(input action_state_t s, input int h, input logic [6:0] f, input bit nt);
    exp_t e;
    e.st = s;
    e.hp = 8'(h);
    e.fl = f;
    e.tk = tk + (nt ? 1 : 0);
    sbq.push_back(e);
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) clk1();
  endtask

  task automatic tick_();
    frame_tick = 1'b1;
    tk++;
    clk1();
    frame_tick = 1'b0;
    cyc(3);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick_();
  endtask

  task automatic press();
    btn_attack = 1'b1;
    clk1();
    btn_attack = 1'b0;
    cyc(1);
  endtask

  task automatic hit1();
    hit = 1'b1;
    clk1();
    hit = 1'b0;
    cyc(1);
  endtask

  task automatic hit_tick();
    hit = 1'b1;
    frame_tick = 1'b1;
    tk++;
    clk1();
    hit = 1'b0;
    frame_tick = 1'b0;
    cyc(3);
  endtask

  // Tick counter
  initial begin
    forever begin
      @(posedge clk);
      if (frame_tick) tk_seen++;
    end
  end

  // Monitor: any strobe, or any change of levels, is an event to check.
  initial begin
    logic [6:0]  fl;
    logic [14:0] lv, last_lv;
    bit          have_last;
    exp_t        e;
    have_last = 1'b0;
    last_lv   = '0;
    forever begin
      @(negedge clk);
      fl = {right, left, jump, squat, defend, atk_active, ko};
      lv = {state, hp, squat, defend, atk_active, ko};
      if (!have_last || (lv !== last_lv) || ({right, left, jump} !== 3'b000)) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event: got state=%0d hp=%0d flags=%b tick=%0d, required no event",
                   state, hp, fl, tk_seen);
        end else begin
          e = sbq.pop_front();
          if ((state !== e.st) || (hp !== e.hp) || (fl !== e.fl) || (tk_seen != e.tk)) begin
            failures++;
            $display("FAIL event%0d: got state=%0d hp=%0d flags=%b tick=%0d, required state=%0d hp=%0d flags=%b tick=%0d",
                     checks, state, hp, fl, tk_seen, e.st, e.hp, e.fl, e.tk);
          end
        end
      end
      last_lv   = lv;
      have_last = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, required finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    ex(IDLE, 25, F_0, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Movement: right x5, both -> right wins, left alone, jump gating
    btn_right = 1'b1;
    repeat (5) begin ex(IDLE, 25, F_R, 1); tick_(); end
    btn_left = 1'b1;
    repeat (2) begin ex(IDLE, 25, F_R, 1); tick_(); end
    btn_right = 1'b0;
    repeat (2) begin ex(IDLE, 25, F_L, 1); tick_(); end
    btn_left = 1'b0;
    btn_jump = 1'b1;
    ex(IDLE, 25, F_J, 1); tick_();
    is_jump = 1'b1;
    tick_();                          // jump blocked while airborne
    is_jump = 1'b0;
    btn_jump = 1'b0;
    // Squat level blocks movement and jump
    btn_squat = 1'b1;
    ex(IDLE, 25, F_S, 0); clk1();
    btn_right = 1'b1;
    btn_jump = 1'b1;
    tick_();
    btn_right = 1'b0;
    btn_jump = 1'b0;
    btn_squat = 1'b0;
    ex(IDLE, 25, F_0, 0);
    cyc(2);

    // Attack round 1
    ex(WINDUP, 25, F_0, 0); press();
    ticks(2); ex(ACTIVE, 25, F_A, 1); tick_();
    tick_(); ex(RECOVER, 25, F_0, 1); tick_();
    ticks(3); ex(IDLE, 25, F_0, 1); tick_();
    // Attack round 2 with buffered re-attack from RECOVER
    ex(WINDUP, 25, F_0, 0); press();
    ticks(2); ex(ACTIVE, 25, F_A, 1); tick_();
    tick_(); ex(RECOVER, 25, F_0, 1); tick_();
    ticks(2); press(); tick_();
    ex(WINDUP, 25, F_0, 1); tick_();
    tick_(); press(); tick_();       // press in WINDUP is dropped
    ex(ACTIVE, 25, F_A, 1); tick_();
    tick_(); ex(RECOVER, 25, F_0, 1); tick_();
    ticks(3); ex(IDLE, 25, F_0, 1); tick_();

    // Hit in WINDUP -> STUN 8 frames, hit during STUN ignored
    ex(WINDUP, 25, F_0, 0); press();
    tick_();
    ex(STUN, 15, F_0, 0); hit1();
    ticks(2); hit1(); ticks(5);
    ex(IDLE, 15, F_0, 1); tick_();

    // Defend held: 30 frames max, 20-frame cooldown, re-entry, defended hit
    btn_defend = 1'b1;
    ex(DEFEND, 15, F_D, 0); clk1();
    ticks(29); ex(IDLE, 15, F_0, 1); tick_();
    ticks(19); ex(DEFEND, 15, F_D, 1); tick_();
    cyc(2);
    ex(DEFEND, 13, F_D, 0); hit1();
    btn_defend = 1'b0;
    ex(IDLE, 13, F_0, 0); clk1();
    cyc(2);

    // Hit and tick together in ACTIVE, full STUN, saturating hit -> KO
    ex(WINDUP, 13, F_0, 0); press();
    ticks(2); ex(ACTIVE, 13, F_A, 1); tick_();
    ex(STUN, 3, F_0, 1); hit_tick();
    ticks(7); ex(IDLE, 3, F_0, 1); tick_();
    ex(KO, 0, F_K, 0); hit1();
    btn_right = 1'b1; btn_attack = 1'b1; btn_defend = 1'b1; btn_jump = 1'b1;
    ticks(2); hit1();
    btn_right = 1'b0; btn_attack = 1'b0; btn_defend = 1'b0; btn_jump = 1'b0;
    cyc(2);
    rst_n = 1'b0;
    ex(IDLE, 25, F_0, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // Asynchronous reset mid-STUN
    ex(WINDUP, 25, F_0, 0); press();
    tick_();
    ex(STUN, 15, F_0, 0); hit1();
    ticks(2);
    rst_n = 1'b0;
    ex(IDLE, 25, F_0, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(4);

    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending events, required 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
